// File: rtl/wbdbgbus_pkg.sv
// rtl/wbdbgbus_pkg.sv - shared constants and types for the debug-bus command path
package wbdbgbus_pkg;

    localparam int CMD_W       = 36;
    localparam int OPCODE_W    = 4;
    localparam int FRAME_BYTES = 5;

    localparam logic [3:0] SYNC_NIBBLE_DEF = 4'hA;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } deframe_state_t;

endpackage

// File: rtl/wbdbgbus_cmd_deframer.sv
// rtl/wbdbgbus_cmd_deframer.sv - assembles 5-byte UART frames into 36-bit debug-bus commands
module wbdbgbus_cmd_deframer
    import wbdbgbus_pkg::*;
#(
    parameter int         TIMEOUT_CLKS = 26042,
    parameter logic [3:0] SYNC_NIBBLE  = SYNC_NIBBLE_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic [CMD_W-1:0]  o_cmd,
    output logic              o_cmd_valid,
    input  logic              i_cmd_ready,
    output logic              o_frame_err,
    output logic [7:0]        o_drop_count
);

    localparam int            TW   = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLKS);
    localparam logic [2:0]    LAST_IDX = 3'(FRAME_BYTES - 1);

    deframe_state_t        state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [OPCODE_W-1:0]   opcode_q, opcode_d;
    logic [31:0]           payload_q, payload_d;
    logic [CMD_W-1:0]      cmd_q, cmd_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [7:0]            drop_q, drop_d;

    logic                  timeout;
    logic                  byte_is_start;
    logic                  issue;
    logic [CMD_W-1:0]      frame;

    // Frame FSM: sync check, byte index, payload shift and inter-byte timeout
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        opcode_d    = opcode_q;
        payload_d   = payload_q;
        frame_err_d = 1'b0;
        issue       = 1'b0;
        frame       = {opcode_q, payload_q[23:0], i_rx_data};

        timeout       = (state_q == DATA) && (timer_q == TMAX);
        // a byte landing in the timeout cycle starts over as if we were idle
        byte_is_start = (state_q == IDLE) || timeout;

        if (timeout) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
            idx_d       = 3'd0;
            timer_d     = '0;
        end

        if (i_rx_valid) begin
            if (byte_is_start) begin
                if (i_rx_data[7:4] == SYNC_NIBBLE) begin
                    opcode_d = i_rx_data[3:0];
                    idx_d    = 3'd1;
                    timer_d  = '0;
                    state_d  = DATA;
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                payload_d = {payload_q[23:0], i_rx_data};
                timer_d   = '0;
                if (idx_q == LAST_IDX) begin
                    issue   = 1'b1;
                    state_d = IDLE;
                    idx_d   = 3'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
        end else if ((state_q == DATA) && !timeout) begin
            timer_d = timer_q + TW'(1);
        end
    end

    // One-deep output register with saturating count of frames lost to backpressure
    always_comb begin
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        drop_d      = drop_q;

        if (issue) begin
            if (!cmd_valid_q || i_cmd_ready) begin
                cmd_d       = frame;
                cmd_valid_d = 1'b1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (cmd_valid_q && i_cmd_ready) begin
            cmd_valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            timer_q     <= '0;
            opcode_q    <= '0;
            payload_q   <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            drop_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            opcode_q    <= opcode_d;
            payload_q   <= payload_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            drop_q      <= drop_d;
        end
    end

    assign o_cmd        = cmd_q;
    assign o_cmd_valid  = cmd_valid_q;
    assign o_frame_err  = frame_err_q;
    assign o_drop_count = drop_q;

endmodule
